uart_receive: RTL



---
 rtl/uart_receive_if.sv | 18 +
 rtl/uart_receive.sv | 112 +++++++++++
 2 files changed

// File: rtl/uart_receive_if.sv
// Receiver-side signal bundle: serial line in, received byte and status out.
interface uart_receive_if;
  logic       rx_wire_in;
  logic [7:0] data_byte_out;
  logic       new_data_out;
  logic       framing_error_out;
  logic       busy_out;

  modport master (
    input  rx_wire_in,
    output data_byte_out, new_data_out, framing_error_out, busy_out
  );

  modport slave (
    output rx_wire_in,
    input  data_byte_out, new_data_out, framing_error_out, busy_out
  );
endinterface

// File: rtl/uart_receive.sv
// 8N1 UART receiver: synchronises rx, samples each bit mid-period, strobes good bytes
// and flags bad stop bits.
module uart_receive #(
  parameter int INPUT_CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE        = 9600
) (
  input  logic           clk_in,
  input  logic           rst_in,
  uart_receive_if.master bus
);

  localparam int P  = INPUT_CLOCK_FREQ / BAUD_RATE;
  localparam int H  = P / 2;
  localparam int CW = $clog2(P) + 1;
  localparam logic [CW-1:0] HALF_END = CW'(H - 1);
  localparam logic [CW-1:0] BIT_END  = CW'(P - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t        state, state_nxt;
  logic [1:0]    sync;
  logic          rx_s;
  logic [CW-1:0] count, count_nxt;
  logic [2:0]    idx, idx_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          load, frame_err;

  assign rx_s = sync[1];

  // Idle-high reset value keeps a reset from looking like a start bit.
  always_ff @(posedge clk_in) begin
    if (rst_in) sync <= 2'b11;
    else        sync <= {sync[0], bus.rx_wire_in};
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
      count <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      idx   <= idx_nxt;
      shift <= shift_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count + 1'b1;
    idx_nxt   = idx;
    shift_nxt = shift;
    load      = 1'b0;
    frame_err = 1'b0;
    case (state)
      IDLE: begin
        count_nxt = '0;
        if (!rx_s) state_nxt = START;
      end
      START: begin
        if (count == HALF_END) begin
          count_nxt = '0;
          idx_nxt   = '0;
          state_nxt = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (count == BIT_END) begin
          count_nxt = '0;
          shift_nxt = {rx_s, shift[7:1]};
          if (idx == 3'd7) state_nxt = STOP;
          else             idx_nxt   = idx + 1'b1;
        end
      end
      STOP: begin
        // Leave right after the mid-stop sample so a following start bit is not missed.
        if (count == BIT_END) begin
          count_nxt = '0;
          if (rx_s) begin
            load      = 1'b1;
            state_nxt = IDLE;
          end else begin
            frame_err = 1'b1;
            state_nxt = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        count_nxt = '0;
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      bus.data_byte_out     <= '0;
      bus.new_data_out      <= 1'b0;
      bus.framing_error_out <= 1'b0;
      bus.busy_out          <= 1'b0;
    end else begin
      bus.new_data_out      <= load;
      bus.framing_error_out <= frame_err;
      bus.busy_out          <= (state_nxt != IDLE);
      if (load) bus.data_byte_out <= shift;
    end
  end

endmodule
